// File: rtl/echo_capture_pkg.sv
// Shared types and width helpers for the echo capture stage.
// Optional build macro: ECHO_CAPTURE_TIMESTAMP_EN widens each result by a 16-bit timestamp.
package echo_capture_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        PUSH   = 2'd3
    } state_e;

    localparam int TS_W = 16;

    function automatic int out_w(input int data_w);
`ifdef ECHO_CAPTURE_TIMESTAMP_EN
        return data_w + TS_W;
`else
        return data_w;
`endif
    endfunction

endpackage

// File: rtl/echo_capture_fifo.sv
// First-word-fall-through result queue; head, valid and count are registered.
module echo_capture_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic                   accept_o,
    output logic                   valid_o,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d, head_s;
    logic             valid_q, pop_s, push_s;

    // Handshake qualification, pointer/occupancy update and next head value
    always_comb begin
        pop_s    = pop_i && (count_q != ZERO_C);
        push_s   = push_i && ((count_q != FULL_C) || pop_s);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_s   = mem_q[rd_ptr_q];
        data_d   = data_q;
        if (pop_s) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        else       rd_ptr_d = rd_ptr_q;
        if (push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        else        wr_ptr_d = wr_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // The incoming word is the new head only when nothing remains ahead of it.
        if (push_s && (count_q == CNT_W'(pop_s))) head_s = wdata_i;
        else                                      head_s = mem_q[rd_ptr_d];
        if (count_d != ZERO_C) data_d = head_s;
        else                   data_d = data_q;
    end

    // Storage array write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer, count and head registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= ZERO_C;
            data_q   <= {WIDTH{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= (count_d != ZERO_C);
        end
    end

    assign accept_o = push_s;
    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign count_o  = count_q;

endmodule

// File: rtl/echo_capture.sv
// Echo capture: synchronise pins, settle, majority-vote samples, queue results.
// Optional build macro: ECHO_CAPTURE_TIMESTAMP_EN prepends a latched 16-bit cycle stamp.
module echo_capture
    import echo_capture_pkg::*;
#(
    parameter int DATA_W        = 6,
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_SAMPLES   = 3,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_W-1:0]           pin_in,
    input  logic                        start,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [out_w(DATA_W)-1:0]    out_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    input  logic                        clear_overflow
);
    localparam int OUT_W     = out_w(DATA_W);
    localparam int VCNT_W    = $clog2(NUM_SAMPLES + 1);
    localparam int PHASE_MAX = (SETTLE_CYCLES > NUM_SAMPLES) ? SETTLE_CYCLES : NUM_SAMPLES;
    localparam int PH_W      = $clog2(PHASE_MAX + 1);
    localparam logic [PH_W-1:0]   SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0]   SAMPLE_LAST = PH_W'(NUM_SAMPLES - 1);
    localparam logic [VCNT_W-1:0] HALF_C      = VCNT_W'(NUM_SAMPLES / 2);

    logic [DATA_W-1:0] sync1_q, sync2_q;
    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [VCNT_W-1:0] ones_q [DATA_W];
    logic [VCNT_W-1:0] ones_d [DATA_W];
    logic [DATA_W-1:0] vote_s;
    logic [OUT_W-1:0]  push_data_s;
    logic              push_s, accept_s, busy_q, overflow_q, overflow_d;

    // Two-flop resynchroniser for the asynchronous pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= {DATA_W{1'b0}};
            sync2_q <= {DATA_W{1'b0}};
        end else begin
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
        end
    end

    // Next state, phase counter and per-bit ones accumulation
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ones_d  = ones_q;
        push_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    phase_d = {PH_W{1'b0}};
                    for (int i = 0; i < DATA_W; i++) ones_d[i] = {VCNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (phase_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                    phase_d = {PH_W{1'b0}};
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            SAMPLE: begin
                for (int i = 0; i < DATA_W; i++) ones_d[i] = ones_q[i] + VCNT_W'(sync2_q[i]);
                if (phase_q == SAMPLE_LAST) begin
                    state_d = PUSH;
                    phase_d = {PH_W{1'b0}};
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            PUSH: begin
                push_s  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                phase_d = {PH_W{1'b0}};
            end
        endcase
    end

    // Majority decision per bit from the completed sample counts
    always_comb begin
        vote_s = {DATA_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) vote_s[i] = (ones_q[i] > HALF_C);
    end

    // A dropped push sets the sticky flag even when a clear arrives together
    always_comb begin
        if (push_s && !accept_s)  overflow_d = 1'b1;
        else if (clear_overflow)  overflow_d = 1'b0;
        else                      overflow_d = overflow_q;
    end

    // Capture FSM, vote counters and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= {PH_W{1'b0}};
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DATA_W; i++) ones_q[i] <= {VCNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            busy_q     <= (state_d != IDLE);
            overflow_q <= overflow_d;
            ones_q     <= ones_d;
        end
    end

`ifdef ECHO_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q, ts_q;

    // Free-running cycle counter, snapshotted as sampling begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_q <= {TS_W{1'b0}};
            ts_q     <= {TS_W{1'b0}};
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_W'(1);
            if ((state_q == SETTLE) && (state_d == SAMPLE)) ts_q <= ts_cnt_q;
            else                                            ts_q <= ts_q;
        end
    end

    assign push_data_s = {ts_q, vote_s};
`else
    assign push_data_s = vote_s;
`endif

    echo_capture_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (push_s),
        .wdata_i  (push_data_s),
        .pop_i    (out_ready),
        .accept_o (accept_s),
        .valid_o  (out_valid),
        .data_o   (out_data),
        .count_o  (fifo_count)
    );

    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_echo_capture.sv
// Randomised and directed bench for echo_capture against a cycle-level behavioural model.
module tb_echo_capture;
    import echo_capture_pkg::*;

    localparam int DW    = 6;
    localparam int S     = 4;
    localparam int N     = 3;
    localparam int D     = 8;
    localparam int OUT_W = out_w(DW);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DW-1:0]    pin_in = '0;
    logic             start = 1'b0;
    logic             out_ready = 1'b0;
    logic             clear_overflow = 1'b0;
    logic             busy, out_valid, overflow;
    logic [OUT_W-1:0] out_data;
    logic [$clog2(D):0] fifo_count;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    echo_capture #(
        .DATA_W(DW), .SETTLE_CYCLES(S), .NUM_SAMPLES(N), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pin_in(pin_in), .start(start), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_count(fifo_count), .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: pins logged per cycle, a capture is its start cycle, results in a queue
    int            cyc = 0;
    logic [DW-1:0] pin_log [4096];
    int            m_start = -1;
    logic [DW-1:0] m_q[$];
    bit            m_ovf = 1'b0;
    logic [DW-1:0] m_last = '0;
    bit            m_idle, m_pop;

    function automatic logic [DW-1:0] vote_of(input int c);
        logic [DW-1:0] r;
        int ones;
        r = '0;
        for (int b = 0; b < DW; b++) begin
            ones = 0;
            // sample j happens in cycle c+S+1+j and sees the pin value of two cycles earlier
            for (int j = 0; j < N; j++) ones += int'(pin_log[(c + S - 1 + j) % 4096][b]);
            r[b] = (ones > N / 2);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        pin_log[cyc % 4096] = pin_in;
        if (!rst_n) begin
            m_start = -1;
            m_q.delete();
            m_ovf  = 1'b0;
            m_last = '0;
        end else begin
            m_idle = (m_start < 0);
            m_pop  = (m_q.size() > 0) && out_ready;
            if (m_pop) void'(m_q.pop_front());
            if (!m_idle && (cyc == m_start + S + N + 1)) begin
                if (m_q.size() < D) m_q.push_back(vote_of(m_start));
                else                m_ovf = 1'b1;
                if (m_q.size() <= D && clear_overflow && m_ovf == 1'b0) m_ovf = 1'b0;
                m_start = -1;
            end else if (clear_overflow) begin
                m_ovf = 1'b0;
            end
            if (m_idle && start) m_start = cyc;
            if (m_q.size() > 0) m_last = m_q[0];
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("busy",       32'(busy),             32'(m_start >= 0));
            check("out_valid",  32'(out_valid),        32'(m_q.size() > 0));
            check("fifo_count", 32'(fifo_count),       32'(m_q.size()));
            check("overflow",   32'(overflow),         32'(m_ovf));
            check("out_data",   32'(out_data[DW-1:0]), 32'(m_last));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // start in cycle c, returns in cycle c+9 (first cycle a new start is honoured)
    task automatic capture(input logic [DW-1:0] v);
        pin_in = v;
        start  = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
    endtask

    task automatic capture_pattern(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [DW-1:0] c);
        pin_in = 6'h15;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        pin_in = a;
        step();
        pin_in = b;
        step();
        pin_in = c;
        repeat (4) step();
    endtask

    task automatic drain_seq(input string name, input int first, input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(name, 32'(out_data[DW-1:0]), 32'(first + i));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",     32'(busy),       32'd0);
        check("rst_valid",    32'(out_valid),  32'd0);
        check("rst_data",     32'(out_data),   32'd0);
        check("rst_count",    32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        step();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step();

        // Steady pins, result visible exactly nine cycles after start
        out_ready = 1'b1;
        pin_in    = 6'h2A;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        @(negedge clk);
        check("t1_valid_c8", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        check("t1_valid_c9", 32'(out_valid), 32'd1);
        check("t1_data",     32'(out_data[DW-1:0]), 32'h2A);
        step();
        @(negedge clk);
        check("t1_count", 32'(fifo_count), 32'd0);

        // Majority vote across differing samples
        capture_pattern(6'h3F, 6'h00, 6'h3F);
        @(negedge clk);
        check("t2_vote_a", 32'(out_data[DW-1:0]), 32'h3F);
        step();
        capture_pattern(6'h00, 6'h01, 6'h01);
        @(negedge clk);
        check("t2_vote_b", 32'(out_data[DW-1:0]), 32'h01);
        step();
        step();

        // Overflow on a full queue, then in-order drain and flag clear
        out_ready = 1'b0;
        for (int v = 1; v <= 9; v++) capture(DW'(v));
        @(negedge clk);
        check("t3_count",    32'(fifo_count), 32'd8);
        check("t3_overflow", 32'(overflow),   32'd1);
        step();
        drain_seq("t3_drain", 1, 8);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        @(negedge clk);
        check("t3_cleared", 32'(overflow), 32'd0);
        step();

        // Starts during SETTLE and SAMPLE are ignored
        pin_in = 6'h2C;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        @(negedge clk);
        check("t4_count", 32'(fifo_count), 32'd1);
        check("t4_busy",  32'(busy),       32'd0);
        step();
        drain_seq("t4_drain", 32'h2C, 1);

        // Full queue with a pop in the PUSH cycle keeps count and takes the new tail
        for (int v = 8'h10; v <= 8'h17; v++) capture(DW'(v));
        pin_in = 6'h18;
        start  = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("t6_count",    32'(fifo_count), 32'd8);
        check("t6_overflow", 32'(overflow),   32'd0);
        step();
        drain_seq("t6_drain", 32'h11, 8);

        // Reset in the middle of sampling aborts the capture
        pin_in = 6'h3C;
        start  = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #2;
        check("t5_busy",  32'(busy),       32'd0);
        check("t5_count", 32'(fifo_count), 32'd0);
        check("t5_valid", 32'(out_valid),  32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        capture(6'h15);
        @(negedge clk);
        check("t5_fresh_valid", 32'(out_valid), 32'd1);
        step();
        drain_seq("t5_fresh", 32'h15, 1);

`ifdef ECHO_CAPTURE_TIMESTAMP_EN
        begin
            logic [15:0] ts0, ts1;
            capture(6'h05);
            capture(6'h06);
            @(negedge clk);
            ts0 = out_data[OUT_W-1:DW];
            out_ready = 1'b1;
            @(negedge clk);
            ts1 = out_data[OUT_W-1:DW];
            check("ts_delta", 32'(16'(ts1 - ts0)), 32'd9);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            drain_seq("ts_tail", 32'h06, 1);
        end
`endif

        // Randomised traffic with phases of light and heavy draining
        for (int k = 0; k < 3000; k++) begin
            pin_in         = DW'($urandom);
            start          = ($urandom_range(0, 5) == 0);
            out_ready      = (((k / 400) % 2) == 0) ? ($urandom_range(0, 3) == 0)
                                                    : ($urandom_range(0, 3) != 0);
            clear_overflow = ($urandom_range(0, 40) == 0);
            step();
        end
        start          = 1'b0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
